appliance_power_arbiter: RTL and testbench

- Shares a limited household power budget among the smart appliances: fridge, oven, coffee maker, washer and dishwasher.
- Appliance command lines become requests. The block issues registered run grants, which drive the appliance status controller in place of the raw commands.
- Enforces a maximum number of concurrently running appliances, minimum on-time, maximum on-time under contention, and post-run cooldown.
- Provides a load-shed input for grid/overload events.

---
 rtl/home_pkg.sv | 17 +
 rtl/appliance_power_arbiter_if.sv | 30 +++
 rtl/appliance_slot_fsm.sv | 87 ++++++++
 rtl/appliance_power_arbiter.sv | 97 +++++++++
 tb/tb_appliance_power_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/home_pkg.sv
// Shared definitions for the household appliance power arbiter.
// Provides appliance index constants and the per-appliance state encoding.
package home_pkg;

  localparam int APPL_FRIDGE     = 0;
  localparam int APPL_OVEN       = 1;
  localparam int APPL_COFFEE     = 2;
  localparam int APPL_WASHER     = 3;
  localparam int APPL_DISHWASHER = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_COOL
  } appl_state_e;

endpackage

// File: rtl/appliance_power_arbiter_if.sv
// Appliance request/grant bundle.
//   req          : level request per appliance
//   prio         : high-priority mask
//   shed         : load-shed, drops all non-priority grants
//   grant        : run enable per appliance
//   active_count : number of set grant bits
//   waiting      : an eligible request could not be granted
// master = appliance/command side, slave = arbiter side.
interface appliance_power_arbiter_if #(
  parameter int N_APPL = 5
);
  localparam int CW = $clog2(N_APPL + 1);

  logic [N_APPL-1:0] req;
  logic [N_APPL-1:0] prio;
  logic              shed;
  logic [N_APPL-1:0] grant;
  logic [CW-1:0]     active_count;
  logic              waiting;

  modport master (
    output req, prio, shed,
    input  grant, active_count, waiting
  );

  modport slave (
    input  req, prio, shed,
    output grant, active_count, waiting
  );
endinterface

// File: rtl/appliance_slot_fsm.sv
// One appliance's IDLE/RUN/COOL state machine with run and cool counters.
//   clk, rst   : clock, asynchronous active-high reset
//   select     : arbiter picked this appliance this cycle (only honoured in IDLE)
//   req, prio  : this appliance's request and priority bits
//   shed       : load-shed event
//   waiting_q  : registered arbiter waiting flag (previous cycle's decision)
//   running    : in RUN (the grant)
//   idle       : in IDLE (may be selected)
module appliance_slot_fsm
  import home_pkg::*;
#(
  parameter int MIN_ON   = 4,
  parameter int MAX_ON   = 16,
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic select,
  input  logic req,
  input  logic prio,
  input  logic shed,
  input  logic waiting_q,
  output logic running,
  output logic idle
);

  localparam int RW = $clog2(MAX_ON + 1);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [RW-1:0] RUN_SAT   = RW'(MAX_ON);
  localparam logic [RW-1:0] MIN_HOLD  = RW'(MIN_ON - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);

  appl_state_e   state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0] cool_cnt_q, cool_cnt_d;
  logic          release_now;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    cool_cnt_d = cool_cnt_q;
    // Shed bypasses the minimum on-time; MAX_ON preemption needs a waiter.
    release_now = ((run_cnt_q >= MIN_HOLD) && !req)
               || (!prio && (run_cnt_q == RUN_SAT) && waiting_q)
               || (shed && !prio);
    unique case (state_q)
      ST_IDLE: begin
        if (select) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (release_now) begin
          state_d    = ST_COOL;
          cool_cnt_d = '0;
        end else if (run_cnt_q != RUN_SAT) begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end
      ST_COOL: begin
        if (cool_cnt_q == COOL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_cnt_q  <= '0;
      cool_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      cool_cnt_q <= cool_cnt_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign idle    = (state_q == ST_IDLE);

endmodule

// File: rtl/appliance_power_arbiter.sv
// Shares the household power budget among N_APPL appliances.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of appliance_power_arbiter_if
//              (req/prio/shed in; grant/active_count/waiting out)
// At most one new grant per cycle, priority class first, round-robin within
// the class. Slot accounting uses registered grants, so a slot freed at an
// edge is reusable from the following decision.
module appliance_power_arbiter
  import home_pkg::*;
#(
  parameter int N_APPL     = 5,
  parameter int MAX_ACTIVE = 2,
  parameter int MIN_ON     = 4,
  parameter int MAX_ON     = 16,
  parameter int COOLDOWN   = 8
) (
  input logic                      clk,
  input logic                      rst,
  appliance_power_arbiter_if.slave bus
);

  localparam int          IW = (N_APPL > 1) ? $clog2(N_APPL) : 1;
  localparam int          CW = $clog2(N_APPL + 1);
  localparam int unsigned NU = N_APPL;

  logic [N_APPL-1:0] running, idle, select_vec;
  logic [N_APPL-1:0] eligible, prio_elig, pick_from;
  logic [IW-1:0]     ptr_q, ptr_d, pick_idx;
  logic              pick_found, grant_ok;
  logic              waiting_q, waiting_d;
  logic [CW-1:0]     active_count;

  for (genvar i = 0; i < N_APPL; i++) begin : g_slot
    appliance_slot_fsm #(
      .MIN_ON   (MIN_ON),
      .MAX_ON   (MAX_ON),
      .COOLDOWN (COOLDOWN)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .select    (select_vec[i]),
      .req       (bus.req[i]),
      .prio      (bus.prio[i]),
      .shed      (bus.shed),
      .waiting_q (waiting_q),
      .running   (running[i]),
      .idle      (idle[i])
    );
  end

  always_comb begin
    active_count = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      active_count = active_count + CW'(running[k]);
    end
  end

  always_comb begin : p_pick
    int unsigned cand;
    cand       = 0;
    eligible   = bus.req & idle & (bus.shed ? bus.prio : '1);
    prio_elig  = eligible & bus.prio;
    pick_from  = (|prio_elig) ? prio_elig : eligible;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      cand = (32'(ptr_q) + 32'd1 + k) % NU;
      if (!pick_found && pick_from[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
    grant_ok   = pick_found && (active_count < CW'(MAX_ACTIVE));
    select_vec = '0;
    ptr_d      = ptr_q;
    if (grant_ok) begin
      select_vec[pick_idx] = 1'b1;
      ptr_d                = pick_idx;
    end
    waiting_d = (|eligible) && (active_count >= CW'(MAX_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= IW'(N_APPL - 1);
      waiting_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      waiting_q <= waiting_d;
    end
  end

  assign bus.grant        = running;
  assign bus.active_count = active_count;
  assign bus.waiting      = waiting_q;

endmodule

// File: tb/tb_appliance_power_arbiter.sv
// Directed bench for appliance_power_arbiter (N_APPL=5, MAX_ACTIVE=2,
// MIN_ON=4, MAX_ON=16, COOLDOWN=8). Expected outputs are queued before each
// edge and compared one time unit after it.
module tb_appliance_power_arbiter;

  typedef struct {
    string      tag;
    logic [4:0] g;
    logic [2:0] c;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  appliance_power_arbiter_if #(.N_APPL(5)) bus ();

  appliance_power_arbiter #(
    .N_APPL     (5),
    .MAX_ACTIVE (2),
    .MIN_ON     (4),
    .MAX_ON     (16),
    .COOLDOWN   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic expect_out(input string tag, input logic [4:0] g,
                            input logic [2:0] c, input logic w);
    exp_t e;
    e.tag = tag; e.g = g; e.c = c; e.w = w;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (bus.grant === e.g) n_pass++;
      else $error("FAIL %s grant: got %b want %b", e.tag, bus.grant, e.g);
      n_checks++;
      assert (bus.active_count === e.c) n_pass++;
      else $error("FAIL %s active_count: got %0d want %0d", e.tag, bus.active_count, e.c);
      n_checks++;
      assert (bus.waiting === e.w) n_pass++;
      else $error("FAIL %s waiting: got %b want %b", e.tag, bus.waiting, e.w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_checks++;
    assert (bus.active_count <= 3'd2) n_pass++;
    else $error("FAIL max_active: got %0d want <=2", bus.active_count);
    drain();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.prio = '0;
    bus.shed = 1'b0;
    #12;
    expect_out("reset", 5'b00000, 3'd0, 1'b0);
    drain();
    rst = 1'b0;
    tick();

    // Reset mid-run, then regrant with no cooldown
    bus.req = 5'b00011;
    expect_out("s1_e1", 5'b00001, 3'd1, 1'b0); tick();
    expect_out("s1_e2", 5'b00011, 3'd2, 1'b0); tick();
    expect_out("s1_e3", 5'b00011, 3'd2, 1'b0); tick();
    #2 rst = 1'b1;
    #1;
    expect_out("s1_async_rst", 5'b00000, 3'd0, 1'b0); drain();
    #2 rst = 1'b0;
    expect_out("s1_regrant_a", 5'b00001, 3'd1, 1'b0); tick();
    expect_out("s1_regrant_b", 5'b00011, 3'd2, 1'b0); tick();
    bus.req = '0;
    ticks(20);
    expect_out("s1_quiet", 5'b00000, 3'd0, 1'b0); tick();

    // Three simultaneous requests, two slots
    bus.req = 5'b11100;
    expect_out("s2_e1", 5'b00100, 3'd1, 1'b0); tick();
    expect_out("s2_e2", 5'b01100, 3'd2, 1'b0); tick();
    expect_out("s2_e3_wait", 5'b01100, 3'd2, 1'b1); tick();
    bus.req = '0;
    expect_out("s2_minon_hold", 5'b01100, 3'd2, 1'b0); tick();
    expect_out("s2_rel_bit2", 5'b01000, 3'd1, 1'b0); tick();
    expect_out("s2_rel_bit3", 5'b00000, 3'd0, 1'b0); tick();
    ticks(12);

    // One-cycle pulse: MIN_ON hold, cooldown, re-request ignored in COOL
    bus.req = 5'b00001;
    expect_out("s3_e1", 5'b00001, 3'd1, 1'b0); tick();
    bus.req = '0;
    for (int k = 2; k <= 4; k++) begin
      expect_out($sformatf("s3_hold_e%0d", k), 5'b00001, 3'd1, 1'b0); tick();
    end
    expect_out("s3_release", 5'b00000, 3'd0, 1'b0); tick();
    bus.req = 5'b00001;
    for (int k = 6; k <= 13; k++) begin
      expect_out($sformatf("s3_cool_e%0d", k), 5'b00000, 3'd0, 1'b0); tick();
    end
    expect_out("s3_regrant", 5'b00001, 3'd1, 1'b0); tick();
    bus.req = '0;
    ticks(14);

    // MAX_ON preemption and rotation across three requesters
    bus.req = 5'b00111;
    expect_out("s4_e1", 5'b00010, 3'd1, 1'b0); tick();
    expect_out("s4_e2", 5'b00110, 3'd2, 1'b0); tick();
    expect_out("s4_e3", 5'b00110, 3'd2, 1'b1); tick();
    ticks(13);
    expect_out("s4_e17", 5'b00110, 3'd2, 1'b1); tick();
    expect_out("s4_maxon_b1", 5'b00100, 3'd1, 1'b1); tick();
    expect_out("s4_maxon_b2", 5'b00001, 3'd1, 1'b0); tick();
    ticks(6);
    expect_out("s4_e26", 5'b00001, 3'd1, 1'b0); tick();
    expect_out("s4_e27", 5'b00011, 3'd2, 1'b0); tick();
    expect_out("s4_e28", 5'b00011, 3'd2, 1'b1); tick();
    ticks(7);
    expect_out("s4_maxon_b0", 5'b00010, 3'd1, 1'b1); tick();
    expect_out("s4_rotate_b2", 5'b00110, 3'd2, 1'b0); tick();
    bus.req = '0;
    ticks(16);

    // Priority appliance waits, wins the next slot, is never preempted
    bus.prio = 5'b00001;
    bus.req  = 5'b00110;
    expect_out("s5_e1", 5'b00010, 3'd1, 1'b0); tick();
    expect_out("s5_e2", 5'b00110, 3'd2, 1'b0); tick();
    bus.req = 5'b01111;
    expect_out("s5_e3", 5'b00110, 3'd2, 1'b1); tick();
    ticks(14);
    expect_out("s5_e18", 5'b00100, 3'd1, 1'b1); tick();
    expect_out("s5_prio_first", 5'b00001, 3'd1, 1'b0); tick();
    expect_out("s5_e20", 5'b01001, 3'd2, 1'b0); tick();
    ticks(15);
    expect_out("s5_prio_kept", 5'b01001, 3'd2, 1'b1); tick();
    expect_out("s5_e37", 5'b00001, 3'd1, 1'b1); tick();
    expect_out("s5_e38", 5'b00011, 3'd2, 1'b0); tick();
    ticks(11);
    expect_out("s5_e50", 5'b00011, 3'd2, 1'b1); tick();

    // Load shed with grant=00011, prio=00001
    bus.shed = 1'b1;
    expect_out("s6_shed", 5'b00001, 3'd1, 1'b0); tick();
    ticks(3);
    expect_out("s6_shed_hold", 5'b00001, 3'd1, 1'b0); tick();
    bus.shed = 1'b0;
    expect_out("s6_unshed", 5'b00101, 3'd2, 1'b0); tick();
    expect_out("s6_wait", 5'b00101, 3'd2, 1'b1); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
